// File: rtl/song_pkg.sv
// Shared widths, ROM word layout and FSM encoding for the song reader.
// Combinational helpers only; no latency.
// No flow control lives here.
package song_pkg;

    localparam int ADDR_W = 7;
    localparam int SONG_W = 2;
    localparam int IDX_W  = ADDR_W - SONG_W;
    localparam int NOTE_W = 6;
    localparam int DUR_W  = 6;
    localparam int WORD_W = NOTE_W + DUR_W;

    // Note 0 is a rest and is played like any other note.
    localparam logic [NOTE_W-1:0] REST_NOTE = '0;
    // A zero duration marks the end of a song and is never issued.
    localparam logic [DUR_W-1:0]  END_DUR   = '0;
    localparam logic [IDX_W-1:0]  IDX_LAST  = '1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_WAIT   = 3'd3,
        ST_PAUSE  = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    function automatic logic [NOTE_W-1:0] note_of(input logic [WORD_W-1:0] w);
        return w[WORD_W-1:DUR_W];
    endfunction

    function automatic logic [DUR_W-1:0] dur_of(input logic [WORD_W-1:0] w);
        return w[DUR_W-1:0];
    endfunction

endpackage

// File: rtl/song_reader.sv
// Walks one song in the song ROM and hands each {note,duration} word to the note player.
// Latency: play seen in IDLE at cycle N -> new_note at N+3 (FETCH, DECODE, WAIT).
// Backpressure: holds each note until note_done; play=0 parks in PAUSE at the next note boundary.
// Optional build macro SONG_READER_LOOP_EN: restart the same song after DONE instead of idling.
module song_reader
    import song_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              play,
    input  logic [SONG_W-1:0] song_sel,
    input  logic              note_done,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [WORD_W-1:0] rom_dout,
    output logic              new_note,
    output logic [NOTE_W-1:0] note,
    output logic [DUR_W-1:0]  duration,
    output logic              song_done,
    output logic              busy
);

    state_t              state_q, state_d;
    logic [SONG_W-1:0]   song_q, song_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [NOTE_W-1:0]   note_q, note_d;
    logic [DUR_W-1:0]    dur_q, dur_d;
    logic                new_note_q, new_note_d;
    logic                song_changed;

    // A song switch is only honoured while a song is in progress (not IDLE/DONE).
    always_comb begin
        song_changed = 1'b0;
        if (state_q inside {ST_FETCH, ST_DECODE, ST_WAIT, ST_PAUSE}) begin
            song_changed = (song_sel != song_q);
        end
    end

    // Next-state logic: sequencing through the song, pause, end-of-song and abort.
    always_comb begin
        state_d    = state_q;
        song_d     = song_q;
        idx_d      = idx_q;
        note_d     = note_q;
        dur_d      = dur_q;
        new_note_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (play) begin
                    song_d  = song_sel;
                    idx_d   = '0;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                // Address is presented this cycle; the registered ROM answers next cycle.
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                if (dur_of(rom_dout) == END_DUR) begin
                    state_d = ST_DONE;
                end else begin
                    note_d     = note_of(rom_dout);
                    dur_d      = dur_of(rom_dout);
                    new_note_d = 1'b1;
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (note_done) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = play ? ST_FETCH : ST_PAUSE;
                    end
                end
            end
            ST_PAUSE: begin
                if (play) begin
                    state_d = ST_FETCH;
                end
            end
            ST_DONE: begin
                idx_d = '0;
`ifdef SONG_READER_LOOP_EN
                state_d = play ? ST_FETCH : ST_PAUSE;
`else
                state_d = ST_IDLE;
`endif
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase

        // Switching songs mid-play drops the current song without a song_done.
        if (song_changed) begin
            state_d    = ST_IDLE;
            idx_d      = '0;
            note_d     = note_q;
            dur_d      = dur_q;
            new_note_d = 1'b0;
        end
    end

    // State, position and current-note registers; reset aborts at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            song_q     <= '0;
            idx_q      <= '0;
            note_q     <= REST_NOTE;
            dur_q      <= '0;
            new_note_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            song_q     <= song_d;
            idx_q      <= idx_d;
            note_q     <= note_d;
            dur_q      <= dur_d;
            new_note_q <= new_note_d;
        end
    end

    assign rom_addr  = {song_q, idx_q};
    assign new_note  = new_note_q;
    assign note      = note_q;
    assign duration  = dur_q;
    assign song_done = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_song_reader.sv
// Directed bench for song_reader with a registered song ROM model and a
// note player model that returns note_done 4 cycles after each new_note.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_song_reader;
    import song_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              play = 1'b0;
    logic [SONG_W-1:0] song_sel = '0;
    logic              note_done;
    logic [ADDR_W-1:0] rom_addr;
    logic [WORD_W-1:0] rom_dout;
    logic              new_note;
    logic [NOTE_W-1:0] note;
    logic [DUR_W-1:0]  duration;
    logic              song_done;
    logic              busy;

    int vectors = 0;
    int miscompares = 0;

    logic [WORD_W-1:0] rom [0:127];
    logic [3:0]        nd_sr;

    song_reader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .play      (play),
        .song_sel  (song_sel),
        .note_done (note_done),
        .rom_addr  (rom_addr),
        .rom_dout  (rom_dout),
        .new_note  (new_note),
        .note      (note),
        .duration  (duration),
        .song_done (song_done),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_dout <= rom[rom_addr];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) nd_sr <= '0;
        else        nd_sr <= {nd_sr[2:0], new_note};
    end
    assign note_done = nd_sr[3];

    // Song 0: 28 notes (entry 3 is a rest), end marker at 28.
    function automatic logic [11:0] s0_word(input int i);
        logic [5:0] n, d;
        n = 6'((i * 5 + 7) % 64);
        d = 6'((i % 9) + 1);
        if (i == 0)       return {6'd49, 6'd12};
        else if (i == 3)  return {6'd0, 6'd5};
        else if (i == 27) return {6'd20, 6'd8};
        else if (i == 28) return {6'd10, 6'd0};
        return {n, d};
    endfunction

    // Song 2: 32 notes, no end marker.
    function automatic logic [11:0] s2_word(input int i);
        logic [5:0] n, d;
        n = 6'(i + 1);
        d = 6'((i % 7) + 2);
        if (i == 0)      return {6'd43, 6'd6};
        else if (i == 1) return {6'd44, 6'd8};
        return {n, d};
    endfunction

    initial begin
        for (int a = 0; a < 128; a++) begin
            case (a / 32)
                0: rom[a] = s0_word(a % 32);
                1: case (a % 32)
                       0:       rom[a] = {6'd35, 6'd36};
                       1:       rom[a] = {6'd42, 6'd36};
                       2:       rom[a] = {6'd38, 6'd54};
                       3:       rom[a] = 12'd0;
                       default: rom[a] = {6'd1, 6'd1};
                   endcase
                2: rom[a] = s2_word(a % 32);
                default: rom[a] = (a == 96) ? 12'd0 : {6'd2, 6'd2};
            endcase
        end
    end

    task automatic test_reset;
        rst_n = 1'b0; play = 1'b0; song_sel = '0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({rom_addr, note, duration, new_note, song_done, busy} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got addr=%0d note=%0d dur=%0d nn=%b sd=%b busy=%b, expected all 0",
                     rom_addr, note, duration, new_note, song_done, busy);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_hold_busy: got %b expected 0", busy);
        end
    endtask

    task automatic test_first_notes;
        logic [11:0] got [2];
        int  k;
        bit  done;
        k = 0; done = 0;
        got[0] = '0; got[1] = '0;
        song_sel = 2'd1; play = 1'b1;
        @(negedge clk);
        vectors++;
        if (rom_addr !== 7'd32 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL s1_fetch_addr: got addr=%0d busy=%b expected 32/1", rom_addr, busy);
        end
        @(negedge clk);
        vectors++;
        if (new_note !== 1'b0) begin
            miscompares++;
            $display("FAIL s1_early_new_note: got %b expected 0", new_note);
        end
        @(negedge clk);
        vectors++;
        if (new_note !== 1'b1 || {note, duration} !== {6'd35, 6'd36}) begin
            miscompares++;
            $display("FAIL s1_first_note: got nn=%b note=%0d dur=%0d expected 1 35/36", new_note, note, duration);
        end
        @(negedge clk);
        vectors++;
        if (new_note !== 1'b0 || note !== 6'd35) begin
            miscompares++;
            $display("FAIL s1_pulse_hold: got nn=%b note=%0d expected 0 35", new_note, note);
        end
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            if (new_note) begin
                if (k < 2) got[k] = {note, duration};
                k++;
            end
            if (song_done) begin done = 1; play = 1'b0; end
        end
        vectors++;
        if (!done || k != 2 || got[0] !== {6'd42, 6'd36} || got[1] !== {6'd38, 6'd54}) begin
            miscompares++;
            $display("FAIL s1_next_notes: got done=%0d count=%0d w0=%h w1=%h expected 1 2 %h %h",
                     done, k, got[0], got[1], {6'd42, 6'd36}, {6'd38, 6'd54});
        end
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL s1_busy_after_done: got %b expected 0", busy);
        end
    endtask

    task automatic test_full_song;
        int n, bad;
        bit done;
        logic [11:0] w, first_w, last_w;
        n = 0; bad = 0; done = 0; first_w = '0; last_w = '0;
        song_sel = 2'd0; play = 1'b1;
        for (int c = 0; c < 400 && !done; c++) begin
            @(negedge clk);
            if (new_note) begin
                w = {note, duration};
                if (n == 0) first_w = w;
                last_w = w;
                if (w !== s0_word(n)) bad++;
                n++;
            end
            if (song_done) begin done = 1; play = 1'b0; end
        end
        vectors++;
        if (!done || n != 28) begin
            miscompares++;
            $display("FAIL s0_note_count: got done=%0d count=%0d expected 1 28", done, n);
        end
        vectors++;
        if (first_w !== {6'd49, 6'd12} || last_w !== {6'd20, 6'd8}) begin
            miscompares++;
            $display("FAIL s0_first_last: got %h %h expected %h %h", first_w, last_w, {6'd49, 6'd12}, {6'd20, 6'd8});
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL s0_sequence: got %0d wrong words expected 0", bad);
        end
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || new_note !== 1'b0) begin
            miscompares++;
            $display("FAIL s0_idle_after: got busy=%b nn=%b expected 0 0", busy, new_note);
        end
    endtask

    task automatic test_empty_song;
        int nn;
        nn = 0;
        song_sel = 2'd3; play = 1'b1;
        @(negedge clk);
        vectors++;
        if (rom_addr !== 7'd96) begin
            miscompares++;
            $display("FAIL s3_fetch_addr: got %0d expected 96", rom_addr);
        end
        @(negedge clk);
        if (new_note) nn++;
        @(negedge clk);
        if (new_note) nn++;
        vectors++;
        if (song_done !== 1'b1) begin
            miscompares++;
            $display("FAIL s3_done_timing: got %b expected 1", song_done);
        end
        play = 1'b0;
        @(negedge clk);
        if (new_note) nn++;
        vectors++;
        if (song_done !== 1'b0 || busy !== 1'b0 || nn != 0) begin
            miscompares++;
            $display("FAIL s3_after_done: got sd=%b busy=%b new_notes=%0d expected 0 0 0", song_done, busy, nn);
        end
    endtask

    task automatic test_pause;
        bit found, done;
        int nn, n;
        logic [11:0] last_w;
        found = 0; done = 0; nn = 0; n = 0; last_w = '0;
        song_sel = 2'd2; play = 1'b1;
        for (int c = 0; c < 10 && !found; c++) begin
            @(negedge clk);
            if (new_note) found = 1;
        end
        vectors++;
        if (!found || {note, duration} !== {6'd43, 6'd6}) begin
            miscompares++;
            $display("FAIL s2_first_note: got found=%0d note=%0d dur=%0d expected 1 43/6", found, note, duration);
        end
        play = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (new_note) nn++;
        end
        vectors++;
        if (rom_addr !== 7'd65 || busy !== 1'b1 || nn != 0) begin
            miscompares++;
            $display("FAIL s2_paused: got addr=%0d busy=%b new_notes=%0d expected 65 1 0", rom_addr, busy, nn);
        end
        play = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (new_note !== 1'b1 || {note, duration} !== {6'd44, 6'd8}) begin
            miscompares++;
            $display("FAIL s2_resume_note: got nn=%b note=%0d dur=%0d expected 1 44/8", new_note, note, duration);
        end
        for (int c = 0; c < 400 && !done; c++) begin
            @(negedge clk);
            if (new_note) begin n++; last_w = {note, duration}; end
            if (song_done) begin done = 1; play = 1'b0; end
        end
        vectors++;
        if (!done || n != 30 || last_w !== s2_word(31)) begin
            miscompares++;
            $display("FAIL s2_idx31_end: got done=%0d count=%0d last=%h expected 1 30 %h", done, n, last_w, s2_word(31));
        end
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL s2_busy_after_done: got %b expected 0", busy);
        end
    endtask

    task automatic test_song_change;
        bit found;
        int sd;
        found = 0; sd = 0;
        song_sel = 2'd1; play = 1'b1;
        for (int c = 0; c < 10 && !found; c++) begin
            @(negedge clk);
            if (new_note) found = 1;
        end
        vectors++;
        if (!found || {note, duration} !== {6'd35, 6'd36}) begin
            miscompares++;
            $display("FAIL chg_first_note: got found=%0d note=%0d dur=%0d expected 1 35/36", found, note, duration);
        end
        song_sel = 2'd2;
        @(negedge clk);
        if (song_done) sd++;
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL chg_abort_idle: got busy=%b expected 0", busy);
        end
        @(negedge clk);
        if (song_done) sd++;
        vectors++;
        if (rom_addr !== 7'd64 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL chg_restart_addr: got addr=%0d busy=%b expected 64 1", rom_addr, busy);
        end
        found = 0;
        for (int c = 0; c < 10 && !found; c++) begin
            @(negedge clk);
            if (song_done) sd++;
            if (new_note) found = 1;
        end
        vectors++;
        if (!found || {note, duration} !== {6'd43, 6'd6} || sd != 0) begin
            miscompares++;
            $display("FAIL chg_new_song: got found=%0d note=%0d dur=%0d song_done=%0d expected 1 43/6 0",
                     found, note, duration, sd);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({rom_addr, note, duration, new_note, song_done, busy} !== '0) begin
            miscompares++;
            $display("FAIL midwait_reset: got addr=%0d note=%0d dur=%0d nn=%b sd=%b busy=%b expected all 0",
                     rom_addr, note, duration, new_note, song_done, busy);
        end
        play = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_end_behaviour;
        bit done;
        done = 0;
        song_sel = 2'd0; play = 1'b1;
        for (int c = 0; c < 400 && !done; c++) begin
            @(negedge clk);
            if (song_done) done = 1;
        end
        vectors++;
        if (!done) begin
            miscompares++;
            $display("FAIL end_song_done: got no song_done within budget, expected a pulse");
        end
`ifdef SONG_READER_LOOP_EN
        @(negedge clk);
        vectors++;
        if (rom_addr !== 7'd0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL loop_refetch: got addr=%0d busy=%b expected 0 1", rom_addr, busy);
        end
`else
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL restart_idle_cycle: got busy=%b expected 0", busy);
        end
        @(negedge clk);
        vectors++;
        if (rom_addr !== 7'd0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL restart_fetch: got addr=%0d busy=%b expected 0 1", rom_addr, busy);
        end
`endif
        play = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_first_notes();
        test_full_song();
        test_empty_song();
        test_pause();
        test_song_change();
        test_end_behaviour();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
